// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and status pulses out.
// Optional parity_error signal exists only when UART_PARITY_EN is defined.
`default_nettype none

interface uart_rx_if;
  logic       uart_rx;
  logic [7:0] uart_data;
  logic       uart_data_valid;
  logic       frame_error;
`ifdef UART_PARITY_EN
  logic       parity_error;
`endif

  // master: line driver / byte consumer
  modport master (
    output uart_rx,
    input  uart_data, uart_data_valid, frame_error
`ifdef UART_PARITY_EN
    , input parity_error
`endif
  );

  // slave: the receiver itself
  modport slave (
    input  uart_rx,
    output uart_data, uart_data_valid, frame_error
`ifdef UART_PARITY_EN
    , output parity_error
`endif
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with start/stop validation and framing errors.
// Define UART_PARITY_EN to add an even-parity bit, the PARITY state and parity_error.
`default_nettype none

module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);
  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  generate
    if (CPB < 4) begin : g_bad_cpb
      $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_rx: DATA_BITS must be in 5..8");
    end
  endgenerate

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic                 rx_meta, rx_s;
  logic [2:0]           state, state_nx;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [7:0]           data_q;
  logic                 valid_q, ferr_q;
  logic                 half_tick, bit_tick, last_bit, stop_sample;
  logic                 cnt_run, bit_clr, shift_en, deliver, framing;
`ifdef UART_PARITY_EN
  logic                 par_bit, par_sample, par_fail, perr_q;
`endif

  assign half_tick   = (baud_cnt == HALF_LAST);
  assign bit_tick    = (baud_cnt == BIT_LAST);
  assign last_bit    = (bit_cnt == LAST_BIT);
  assign stop_sample = (state == S_STOP) && bit_tick;

  // Two-flop synchroniser; idle-high reset keeps a false start from appearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.uart_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (!rx_s) state_nx = S_START;
      S_START:  if (half_tick) state_nx = rx_s ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
      S_DATA:   if (bit_tick && last_bit) state_nx = S_PARITY;
      S_PARITY: if (bit_tick) state_nx = S_STOP;
`else
      S_DATA:   if (bit_tick && last_bit) state_nx = S_STOP;
`endif
      // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
      S_STOP:   if (bit_tick) state_nx = rx_s ? S_IDLE : S_BREAK;
      S_BREAK:  if (rx_s) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_run  = 1'b0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
`ifdef UART_PARITY_EN
    par_sample = 1'b0;
`endif
    case (state)
      S_IDLE:   bit_clr = 1'b1;
      S_START:  begin cnt_run = !half_tick; bit_clr = 1'b1; end
      S_DATA:   begin cnt_run = !bit_tick; shift_en = bit_tick; end
`ifdef UART_PARITY_EN
      S_PARITY: begin cnt_run = !bit_tick; par_sample = bit_tick; end
`endif
      S_STOP:   cnt_run = !bit_tick;
      default:  ;
    endcase
    framing = stop_sample && !rx_s;
`ifdef UART_PARITY_EN
    deliver  = stop_sample && rx_s && !(^shift_reg ^ par_bit);
    par_fail = stop_sample && rx_s &&  (^shift_reg ^ par_bit);
`else
    deliver  = stop_sample && rx_s;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      baud_cnt <= cnt_run ? baud_cnt + 1'b1 : '0;
      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      if (deliver)  data_q <= 8'(shift_reg);
      valid_q <= deliver;
      ferr_q  <= framing;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bit <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (par_sample) par_bit <= rx_s;
      perr_q <= par_fail;
    end
  end
  assign bus.parity_error = perr_q;
`endif

  assign bus.uart_data       = data_q;
  assign bus.uart_data_valid = valid_q;
  assign bus.frame_error     = ferr_q;
endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with an expected-byte queue checked on each valid pulse.
`default_nettype none

module tb_uart_rx;
  localparam int CPB = 50000000 / 115200;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .DATA_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (bus.uart_data_valid) begin
      valid_cnt++;
      chk("queue_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rx_byte", 32'(bus.uart_data), 32'(e));
      end
      chk("valid_one_cycle", 32'(prev_valid), 0);
    end
    if (bus.frame_error) begin
      ferr_cnt++;
      chk("valid_ferr_exclusive", 32'(bus.uart_data_valid), 0);
    end
`ifdef UART_PARITY_EN
    if (bus.parity_error) begin
      perr_cnt++;
      chk("valid_perr_exclusive", 32'(bus.uart_data_valid), 0);
    end
`endif
    prev_valid = bus.uart_data_valid;
  end

  task automatic drive_bit(input logic b);
    bus.uart_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_bit);
  endtask

`ifdef UART_PARITY_EN
  task automatic send_par_frame(input logic [7:0] d, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(1'b1);
  endtask
`endif

  task automatic idle(input int n);
    bus.uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #(150000 * 10);
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bus.uart_rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(bus.uart_data), 0);
    chk("reset_valid", 32'(bus.uart_data_valid), 0);
    chk("reset_ferr", 32'(bus.frame_error), 0);
`ifdef UART_PARITY_EN
    chk("reset_perr", 32'(bus.parity_error), 0);
`endif
    reset = 1'b0;
    idle(10);

    // Two isolated bytes; the first must be delivered within its own stop bit.
    exp_q.push_back(8'hF2);
    send_frame(8'hF2, 1'b1);
    chk("t1_first_in_stop", 32'(valid_cnt), 1);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    idle(20);
    chk("t1_drain", 32'(exp_q.size()), 0);
    chk("t1_valid_cnt", 32'(valid_cnt), 2);
    chk("t1_ferr_cnt", 32'(ferr_cnt), 0);

    // Back-to-back with a single stop bit and no idle gap.
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h09);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h09, 1'b1);
    idle(20);
    chk("t2_drain", 32'(exp_q.size()), 0);
    chk("t2_valid_cnt", 32'(valid_cnt), 4);
    chk("t2_ferr_cnt", 32'(ferr_cnt), 0);

    // Short low glitch is a false start.
    bus.uart_rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(2 * CPB);
    chk("t3_glitch_valid", 32'(valid_cnt), 4);
    chk("t3_glitch_ferr", 32'(ferr_cnt), 0);
    chk("t3_data_held", 32'(bus.uart_data), 32'h09);
    exp_q.push_back(8'h05);
    send_frame(8'h05, 1'b1);
    idle(20);
    chk("t3_valid_cnt", 32'(valid_cnt), 5);

    // Low stop bit followed by a long break.
    send_frame(8'hF3, 1'b0);
    repeat (5000) @(negedge clk);
    idle(2 * CPB);
    chk("t4_ferr_cnt", 32'(ferr_cnt), 1);
    chk("t4_valid_cnt", 32'(valid_cnt), 5);
    chk("t4_data_held", 32'(bus.uart_data), 32'h05);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    idle(20);
    chk("t4_next_valid", 32'(valid_cnt), 6);
    chk("t4_next_ferr", 32'(ferr_cnt), 1);

    // Reset in the middle of data bit 4 aborts the frame.
    d = 8'hF1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    bus.uart_rx = d[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_async_data", 32'(bus.uart_data), 0);
    chk("t5_async_valid", 32'(bus.uart_data_valid), 0);
    chk("t5_async_ferr", 32'(bus.frame_error), 0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    idle(3 * CPB);
    chk("t5_abort_valid", 32'(valid_cnt), 6);
    chk("t5_abort_ferr", 32'(ferr_cnt), 1);
    exp_q.push_back(8'hF1);
    send_frame(8'hF1, 1'b1);
    idle(20);
    chk("t5_fresh_valid", 32'(valid_cnt), 7);
    chk("t5_drain", 32'(exp_q.size()), 0);

`ifdef UART_PARITY_EN
    exp_q.push_back(8'hF1);
    send_par_frame(8'hF1, 1'b1);
    idle(20);
    chk("t6_par_ok_valid", 32'(valid_cnt), 8);
    chk("t6_par_ok_perr", 32'(perr_cnt), 0);
    exp_q.push_back(8'h3C);
    send_par_frame(8'h3C, 1'b0);
    idle(20);
    chk("t6_par_ok2_valid", 32'(valid_cnt), 9);
    send_par_frame(8'hF1, 1'b0);
    idle(20);
    chk("t6_par_bad_perr", 32'(perr_cnt), 1);
    chk("t6_par_bad_valid", 32'(valid_cnt), 9);
    chk("t6_par_bad_data", 32'(bus.uart_data), 32'h3C);
    chk("t6_par_bad_ferr", 32'(ferr_cnt), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
